// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-path types and constants.
package ifetch_queue_pkg;

  localparam int WIDTH = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misal;
  } fetch_entry_t;

  // A fetch address is misaligned when it is not word aligned.
  function automatic logic is_misal(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: PC request side, ROM port and decode side.
interface ifetch_queue_if #(
  parameter int WIDTH = 32
);
  logic             pc_valid;
  logic [WIDTH-1:0] pc;
  logic             pc_ready;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic             flush;
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_misal;
  logic             instr_ready;

  modport slave (
    input  pc_valid, pc, mem_rdata, flush, instr_ready,
    output pc_ready, mem_req, mem_addr, instr_valid, instr, instr_pc, instr_misal
  );

  modport master (
    output pc_valid, pc, mem_rdata, flush, instr_ready,
    input  pc_ready, mem_req, mem_addr, instr_valid, instr, instr_pc, instr_misal
  );
endinterface

// File: rtl/ifetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage flops.
module sync_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Next-state: flush wins over everything; a pop of an empty FIFO is ignored.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & ~flush;
    do_pop   = pop & ~flush & (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and pointer registers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues ROM reads for accepted PCs and buffers
// {pc, instr, misal} for decode. A slot is reserved per in-flight read.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int WIDTH = ifetch_queue_pkg::WIDTH,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  ifetch_queue_if.slave bus
);
  localparam int EW = $bits(fetch_entry_t);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    count;
  logic [EW-1:0]    head_raw;
  fetch_entry_t     head;
  fetch_entry_t     wr_entry;
  logic             pc_ready, accept;

  // Credit check uses registered occupancy only, so same-cycle pops never
  // open pc_ready; flush blocks new requests for its cycle.
  always_comb begin
    pc_ready   = ~bus.flush & ((int'(count) + int'(inflight_q)) < DEPTH);
    accept     = bus.pc_valid & pc_ready;
    inflight_d = accept;
    pc_d       = accept ? bus.pc : pc_q;
    wr_entry   = '{pc: pc_q, instr: bus.mem_rdata, misal: is_misal(pc_q)};
  end

  // In-flight read tracking; reset and flush both drop the outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      inflight_q <= inflight_d;
      pc_q       <= pc_d;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (wr_entry),
    .pop       (bus.instr_ready),
    .flush     (bus.flush),
    .count     (count),
    .head      (head_raw)
  );

  assign head            = fetch_entry_t'(head_raw);
  assign bus.pc_ready    = pc_ready;
  assign bus.mem_req     = accept;
  assign bus.mem_addr    = bus.pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
  assign bus.instr_misal = head.misal;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_queue_if #(.WIDTH(32)) bus ();

  ifetch_queue #(.WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
  endfunction

  // ROM model: one-cycle read; garbage marker when not read.
  always @(posedge clk) bus.mem_rdata <= bus.mem_req ? rom(bus.mem_addr) : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;

  // Reference model: queue of entries decode will see, plus one pending read.
  fetch_entry_t mq[$];
  bit           infl;
  logic [31:0]  pend_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check outputs mid-cycle, update model at the clock edge.
  task automatic step(input logic pv, input logic [31:0] p, input logic fl, input logic ir);
    bit exp_rdy, exp_acc;
    fetch_entry_t e;
    bus.pc_valid = pv; bus.pc = p; bus.flush = fl; bus.instr_ready = ir;
    #1;
    exp_rdy = !fl && (mq.size() + int'(infl) < 4);
    exp_acc = pv && exp_rdy;
    chk("pc_ready", bus.pc_ready, exp_rdy);
    chk("mem_req", bus.mem_req, exp_acc);
    if (exp_acc) chk("mem_addr", bus.mem_addr, p);
    chk("instr_valid", bus.instr_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("instr_pc", bus.instr_pc, mq[0].pc);
      chk("instr", bus.instr, mq[0].instr);
      chk("instr_misal", bus.instr_misal, mq[0].misal);
    end
    if (bus.pc_valid && bus.pc_ready) n_acc++;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      infl = 0;
    end else begin
      if (ir && mq.size() != 0) void'(mq.pop_front());
      if (infl) begin
        e.pc = pend_pc; e.instr = rom(pend_pc); e.misal = (pend_pc[1:0] != 2'b00);
        mq.push_back(e);
      end
      infl = exp_acc;
      if (exp_acc) pend_pc = p;
    end
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pc_ready"}, bus.pc_ready, 1'b1);
    chk({tag, "_mem_req"}, bus.mem_req, 1'b0);
    chk({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
    chk({tag, "_instr"}, bus.instr, 32'h0);
    chk({tag, "_instr_pc"}, bus.instr_pc, 32'h0);
    chk({tag, "_instr_misal"}, bus.instr_misal, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.pc_valid = 0; bus.pc = 0; bus.flush = 0; bus.instr_ready = 0;
    infl = 0; pend_pc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Streaming fetch with latency 2 and one instruction per cycle.
    step(1, 32'h0, 0, 1);
    chk("lat_n1_valid", bus.instr_valid, 1'b0);
    step(1, 32'h4, 0, 1);
    chk("lat_n2_valid", bus.instr_valid, 1'b1);
    chk("lat_n2_pc", bus.instr_pc, 32'h0);
    for (int k = 2; k < 12; k++) step(1, 32'(4 * k), 0, 1);
    repeat (3) step(0, 0, 0, 1);

    // Decode stall: exactly DEPTH accepts, then release in order.
    n_acc = 0;
    for (int k = 0; k < 8; k++) step(1, 32'h40 + 32'(4 * k), 0, 0);
    chk("stall_accepts", n_acc, 4);
    repeat (6) step(0, 0, 0, 1);

    // Flush with 3 queued and 1 in flight; pop during flush is ignored.
    for (int k = 0; k < 4; k++) step(1, 32'h80 + 32'(4 * k), 0, 0);
    step(1, 32'h200, 1, 1);
    chk("flush_valid", bus.instr_valid, 1'b0);
    step(1, 32'h100, 0, 0);
    step(0, 0, 0, 0);
    chk("flush_first_valid", bus.instr_valid, 1'b1);
    chk("flush_first_pc", bus.instr_pc, 32'h100);
    repeat (2) step(0, 0, 0, 1);

    // Misaligned tagging.
    step(1, 32'h6, 0, 1);
    step(1, 32'h8, 0, 1);
    chk("misal_pc", bus.instr_pc, 32'h6);
    chk("misal_flag", bus.instr_misal, 1'b1);
    step(0, 0, 0, 1);
    chk("aligned_pc", bus.instr_pc, 32'h8);
    chk("aligned_flag", bus.instr_misal, 1'b0);
    repeat (2) step(0, 0, 0, 1);

    // Full FIFO, push and pop together across several pointer wraps.
    for (int k = 0; k < 4; k++) step(1, 32'h300 + 32'(4 * k), 0, 0);
    for (int k = 4; k < 24; k++) step(1, 32'h300 + 32'(4 * k), 0, 1);
    repeat (6) step(0, 0, 0, 1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 3) != 0), ($urandom & 32'h0000_03FF),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
    repeat (6) step(0, 0, 0, 1);

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 3; k++) step(1, 32'h500 + 32'(4 * k), 0, 0);
    bus.pc_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    mq.delete(); infl = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) step(1, 32'(4 * k), 0, 1);
    repeat (4) step(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
